// File: rtl/sipo_lsb_rx_pkg.sv
// sipo_lsb_rx_pkg: shared state type and sizing helper for the LSB-first SIPO receiver
package sipo_lsb_rx_pkg;
  typedef enum logic {IDLE, SHIFT} sipo_state_e;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/sipo_lsb_rx_if.sv
// sipo_lsb_rx_if: serial input, handshake and status bundle of the SIPO receiver
interface sipo_lsb_rx_if #(parameter int WIDTH = 4);
  logic enb;
  logic frm;
  logic sin;
  logic ack;
  logic clr;
  logic [WIDTH-1:0] par;
  logic vld;
  logic busy;
  logic ovr;
  logic ferr;
  modport master (output enb, frm, sin, ack, clr, input par, vld, busy, ovr, ferr);
  modport slave (input enb, frm, sin, ack, clr, output par, vld, busy, ovr, ferr);
endinterface

// File: rtl/sipo_lsb_rx_shreg.sv
// sipo_shreg: right-shift register, new bit enters at the MSB, sync clear
module sipo_shreg #(parameter int WIDTH = 3) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sh_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    q <= rst ? '0 : sh_en ? (q >> 1) | (WIDTH'(din) << (WIDTH-1)) : q;
endmodule

// File: rtl/sipo_lsb_rx.sv
// sipo_lsb_rx: deframes LSB-first serial words into a held parallel register with valid/ack
module sipo_lsb_rx
  import sipo_lsb_rx_pkg::*;
#(parameter int WIDTH = 4) (
  input logic         clk,
  input logic         rst,
  sipo_lsb_rx_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  sipo_state_e      r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_par;
  logic             r_vld;
  logic             r_ovr;
  logic             r_ferr;
  logic [WIDTH-2:0] w_q;
  logic             w_sh_en;
  logic             w_ferr;
  logic             w_done;
  logic             w_load;
  logic             w_drop;
  logic [WIDTH-1:0] w_word;
  // only the last WIDTH-1 samples are stored; the final bit comes straight from sin
  sipo_shreg #(.WIDTH(WIDTH-1)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .sh_en (w_sh_en),
    .din   (bus.sin),
    .q     (w_q)
  );
  always_comb begin
    w_sh_en = bus.enb && (r_state == SHIFT || bus.frm);
    w_ferr  = bus.enb && r_state == SHIFT && bus.frm;
    w_done  = bus.enb && r_state == SHIFT && !bus.frm && r_cnt == CW'(WIDTH-1);
    w_load  = w_done && (!r_vld || bus.ack);
    w_drop  = w_done && r_vld && !bus.ack;
    w_word  = {bus.sin, w_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_par   <= '0;
      r_vld   <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_sh_en) begin
        r_state <= (bus.frm || r_cnt != CW'(WIDTH-1)) ? SHIFT : IDLE;
        r_cnt   <= bus.frm ? CW'(1) : w_done ? '0 : r_cnt + 1'b1;
      end
      r_par  <= w_load ? w_word : r_par;
      r_vld  <= w_load || (r_vld && !bus.ack);
      r_ovr  <= w_drop || (r_ovr && !bus.clr);
      r_ferr <= w_ferr || (r_ferr && !bus.clr);
    end
  end
  assign bus.par  = r_par;
  assign bus.vld  = r_vld;
  assign bus.busy = (r_state == SHIFT);
  assign bus.ovr  = r_ovr;
  assign bus.ferr = r_ferr;
endmodule

// File: tb/tb_sipo_lsb_rx.sv
// tb_sipo_lsb_rx: scoreboard bench with a bit-queue reference model of the receiver
module tb_sipo_lsb_rx;
  localparam int W = 4;
  typedef struct packed {
    logic [W-1:0] par;
    logic vld;
    logic busy;
    logic ovr;
    logic ferr;
  } obs_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  obs_t exp_q[$];
  bit bits[$];
  bit inword = 0;
  logic [W-1:0] m_par = '0;
  logic m_vld = 0, m_ovr = 0, m_ferr = 0;
  sipo_lsb_rx_if #(.WIDTH(W)) bus();
  sipo_lsb_rx #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  // reference: collect the bits since the last frame; a full word is WIDTH of them
  task automatic model(input bit e, f, s, a, c, r);
    bit done = 0, fe = 0, ov = 0;
    logic [W-1:0] word = '0;
    if (r) begin
      bits = {};
      inword = 0;
      m_par = '0;
      m_vld = 0;
      m_ovr = 0;
      m_ferr = 0;
      return;
    end
    if (e) begin
      if (f) begin
        fe = inword;
        bits = {};
        bits.push_back(s);
        inword = 1;
      end else if (inword) bits.push_back(s);
      if (inword && bits.size() == W) begin
        for (int k = 0; k < W; k++) word = word + (W'(bits[k]) << k);
        done = 1;
        inword = 0;
        bits = {};
      end
    end
    if (done) begin
      if (!m_vld || a) begin
        m_par = word;
        m_vld = 1;
      end else ov = 1;
    end else if (a) m_vld = 0;
    m_ovr = ov | (m_ovr & !c);
    m_ferr = fe | (m_ferr & !c);
  endtask
  task automatic step(input bit e, f, s, a, c, r);
    bus.enb = e;
    bus.frm = f;
    bus.sin = s;
    bus.ack = a;
    bus.clr = c;
    rst = r;
    model(e, f, s, a, c, r);
    exp_q.push_back('{par: m_par, vld: m_vld, busy: inword, ovr: m_ovr, ferr: m_ferr});
    @(posedge clk);
    #2;
  endtask
  task automatic send(input logic [W-1:0] w, input bit ack_last);
    for (int k = 0; k < W; k++) step(1, k == 0, w[k], (k == W-1) && ack_last, 0, 0);
  endtask
  initial begin : monitor
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{par: bus.par, vld: bus.vld, busy: bus.busy, ovr: bus.ovr, ferr: bus.ferr};
        chk("scoreboard", 8'(a), 8'(e));
      end
    end
  end
  initial begin : stim
    bus.enb = 0; bus.frm = 0; bus.sin = 0; bus.ack = 0; bus.clr = 0;
    #2;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_outs", {bus.par, bus.vld, bus.busy, bus.ovr, bus.ferr}, 8'h00);
    send(4'hD, 0);
    chk("t2_par", 8'(bus.par), 8'h0D);
    chk("t2_vld", 8'(bus.vld), 8'h01);
    step(1, 0, 0, 1, 0, 0);
    chk("t2_ack_vld", 8'(bus.vld), 8'h00);
    chk("t2_hold_par", 8'(bus.par), 8'h0D);
    send(4'h3, 0);
    send(4'hA, 0);
    chk("t3_par", 8'(bus.par), 8'h03);
    chk("t3_ovr", 8'(bus.ovr), 8'h01);
    step(1, 0, 0, 0, 1, 0);
    chk("t3_clr", 8'(bus.ovr), 8'h00);
    step(1, 0, 0, 1, 0, 0);
    send(4'h3, 0);
    send(4'h5, 1);
    chk("t4_par", 8'(bus.par), 8'h05);
    chk("t4_vld_ovr", {6'b0, bus.vld, bus.ovr}, 8'h02);
    step(1, 0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    chk("t5_no_partial", 8'(bus.vld), 8'h00);
    send(4'h6, 0);
    chk("t5_ferr", 8'(bus.ferr), 8'h01);
    chk("t5_par", 8'(bus.par), 8'h06);
    step(1, 0, 0, 1, 1, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, i == 1, i[0], 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    chk("t6_par", 8'(bus.par), 8'h09);
    step(1, 0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 1);
    chk("t6_rst", {bus.par, bus.vld, bus.busy, bus.ovr, bus.ferr}, 8'h00);
    send(4'h2, 0);
    chk("t6_after_rst", 8'(bus.par), 8'h02);
    for (int i = 0; i < 400; i++)
      step($urandom_range(3) != 0, $urandom_range(4) == 0, 1'($urandom), $urandom_range(2) == 0,
           $urandom_range(9) == 0, $urandom_range(99) == 0);
    for (int i = 0; i < 20; i++) send(4'($urandom), 1'($urandom));
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
